// File: rtl/guess_entry_nexysa7.sv
// Button-driven 4-digit Bulls & Cows guess entry for the Nexys A7.
// Debounces five push-buttons, edits digits under a cursor, and checks distinctness on commit.
module guess_entry_nexysa7 #(
  parameter int unsigned DEBOUNCE_COUNT = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic        resume,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [15:0] guess,
  output logic        guess_valid,
  output logic        guess_error
);

  typedef enum logic [1:0] {EDIT, CHECK, WAIT} state_t;

  localparam logic [31:0] CNT_LAST = 32'(DEBOUNCE_COUNT - 1);

  // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 center.
  logic [4:0]  raw, s1, s2, db, press;
  logic [31:0] cnt [5];

  assign raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      db    <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int unsigned i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]    <= s2[i];
          cnt[i]   <= '0;
          press[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + 32'd1;
        end
      end
    end
  end

  state_t           state, state_n;
  logic [3:0][3:0]  dig, dig_n;
  logic [1:0]       cursor, cursor_n;
  logic             valid_n, error_n, distinct;

  assign distinct = (dig[0] != dig[1]) && (dig[0] != dig[2]) && (dig[0] != dig[3]) &&
                    (dig[1] != dig[2]) && (dig[1] != dig[3]) && (dig[2] != dig[3]);

  always_comb begin
    state_n  = state;
    dig_n    = dig;
    cursor_n = cursor;
    valid_n  = 1'b0;
    error_n  = 1'b0;
    case (state)
      EDIT: begin
        if (press[4]) begin
          state_n = CHECK;
        end else if (press[0]) begin
          dig_n[cursor] = (dig[cursor] == 4'd9) ? 4'd0 : dig[cursor] + 4'd1;
        end else if (press[1]) begin
          dig_n[cursor] = (dig[cursor] == 4'd0) ? 4'd9 : dig[cursor] - 4'd1;
        end else if (press[2]) begin
          cursor_n = cursor + 2'd1;
        end else if (press[3]) begin
          cursor_n = cursor - 2'd1;
        end
      end
      CHECK: begin
        if (distinct) begin
          valid_n = 1'b1;
          state_n = WAIT;
        end else begin
          error_n = 1'b1;
          state_n = EDIT;
        end
      end
      WAIT: begin
        if (resume) state_n = EDIT;
      end
      default: state_n = EDIT;
    endcase
  end

  // Display codes are registered from next-state values so they change on the same edge as the digits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= EDIT;
      dig         <= {4'd0, 4'd1, 4'd2, 4'd3};
      cursor      <= '0;
      guess_valid <= 1'b0;
      guess_error <= 1'b0;
      d1          <= 6'b100110;
      d2          <= 6'b100101;
      d3          <= 6'b100011;
      d4          <= 6'b100001;
    end else begin
      state       <= state_n;
      dig         <= dig_n;
      cursor      <= cursor_n;
      guess_valid <= valid_n;
      guess_error <= error_n;
      d1          <= {1'b1, dig_n[0], ~((state_n == EDIT) && (cursor_n == 2'd0))};
      d2          <= {1'b1, dig_n[1], ~((state_n == EDIT) && (cursor_n == 2'd1))};
      d3          <= {1'b1, dig_n[2], ~((state_n == EDIT) && (cursor_n == 2'd2))};
      d4          <= {1'b1, dig_n[3], ~((state_n == EDIT) && (cursor_n == 2'd3))};
    end
  end

  assign guess = dig;

endmodule

// File: tb/tb_guess_entry_nexysa7.sv
// Scoreboard bench for guess_entry_nexysa7: a behavioural model queues every expected output
// change; a monitor pops one entry each time the sampled output vector changes.
module tb_guess_entry_nexysa7;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  btn   = '0;   // 0 up, 1 down, 2 left, 3 right, 4 center
  logic        resume = 1'b0;
  logic [5:0]  d1, d2, d3, d4;
  logic [15:0] guess;
  logic        guess_valid, guess_error;

  guess_entry_nexysa7 #(.DEBOUNCE_COUNT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_up      (btn[0]),
    .btn_down    (btn[1]),
    .btn_left    (btn[2]),
    .btn_right   (btn[3]),
    .btn_center  (btn[4]),
    .resume      (resume),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .guess       (guess),
    .guess_valid (guess_valid),
    .guess_error (guess_error)
  );

  always #5 clock = ~clock;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [41:0] exp_q [$];
  logic [41:0] last_v;
  bit          mon_on = 1'b0;

  int mdig [4];
  int mcur;
  bit mwait;

  function automatic logic [41:0] sample();
    return {d4, d3, d2, d1, guess, guess_valid, guess_error};
  endfunction

  function automatic logic [41:0] view(bit edit, bit v, bit e);
    logic [23:0] ds;
    logic [15:0] g;
    for (int i = 0; i < 4; i++) begin
      ds[i*6 +: 6] = {1'b1, 4'(mdig[i]), !(edit && mcur == i)};
      g[i*4 +: 4]  = 4'(mdig[i]);
    end
    return {ds, g, v, e};
  endfunction

  task automatic expect_v(input logic [41:0] v);
    if (v !== last_v) begin
      exp_q.push_back(v);
      last_v = v;
    end
  endtask

  task automatic model_init();
    mdig[0] = 3; mdig[1] = 2; mdig[2] = 1; mdig[3] = 0;
    mcur  = 0;
    mwait = 1'b0;
  endtask

  task automatic model_press(input logic [4:0] m);
    bit ok;
    if (mwait || m == 5'd0) return;
    if (m[4]) begin
      ok = 1'b1;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (mdig[i] == mdig[j]) ok = 1'b0;
      expect_v(view(1'b0, 1'b0, 1'b0));
      if (ok) begin
        mwait = 1'b1;
        expect_v(view(1'b0, 1'b1, 1'b0));
        expect_v(view(1'b0, 1'b0, 1'b0));
      end else begin
        expect_v(view(1'b1, 1'b0, 1'b1));
        expect_v(view(1'b1, 1'b0, 1'b0));
      end
    end else begin
      if (m[0])      mdig[mcur] = (mdig[mcur] + 1) % 10;
      else if (m[1]) mdig[mcur] = (mdig[mcur] + 9) % 10;
      else if (m[2]) mcur = (mcur + 1) % 4;
      else           mcur = (mcur + 3) % 4;
      expect_v(view(1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic drive_btn(input logic [4:0] m, input int hold);
    btn = m;
    repeat (hold) @(posedge clock);
    #1 btn = '0;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    model_press(m);
    drive_btn(m, 10);
  endtask

  task automatic do_resume();
    if (mwait) begin
      mwait = 1'b0;
      expect_v(view(1'b1, 1'b0, 1'b0));
    end
    resume = 1'b1;
    @(posedge clock);
    #1 resume = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    logic [41:0] prev, cur, e;
    wait (mon_on);
    prev = sample();
    forever begin
      @(negedge clock);
      cur = sample();
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change got=%h want=<none queued>", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            miscompares++;
            $display("FAIL output_vector got=%h want=%h", cur, e);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stimulus
    logic [41:0] rst_v;
    logic [15:0] old;
    int first;
    int r;
    logic [4:0] m;

    rst_v = {6'b100001, 6'b100011, 6'b100101, 6'b100110, 16'h0123, 1'b0, 1'b0};
    model_init();
    last_v = view(1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (sample() !== rst_v) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=%h", sample(), rst_v);
    end
    mon_on = 1'b1;
    @(posedge clock);
    #1;

    // Latency: change must appear at edge 7 after the raw rise.
    old = guess;
    model_press(5'b00001);
    btn = 5'b00001;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #2;
      if (first == 0 && guess !== old) first = k;
    end
    btn = '0;
    vectors++;
    if (first != 7) begin
      miscompares++;
      $display("FAIL up_latency got=%0d edges want=7 edges", first);
    end
    repeat (10) @(posedge clock);
    #1;

    drive_btn(5'b00001, 3);
    press(5'b00010);
    repeat (4) press(5'b00010);
    repeat (4) press(5'b00100);
    press(5'b10000);
    press(5'b00001);
    press(5'b00100);
    do_resume();
    repeat (3) press(5'b00001);
    press(5'b10000);
    press(5'b10001);
    press(5'b00001);
    press(5'b10000);

    // Reset in WAIT with btn_up held through deassertion: one press after re-debounce.
    model_init();
    expect_v(view(1'b1, 1'b0, 1'b0));
    model_press(5'b00001);
    reset = 1'b0;
    btn   = 5'b00001;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (12) @(posedge clock);
    #1 btn = '0;
    repeat (10) @(posedge clock);
    #1;

    do_resume();

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        m = 5'd1 << $urandom_range(0, 4);
        press(m);
      end else if (r == 6) begin
        m = 5'($urandom_range(1, 31));
        press(m);
      end else if (r == 7) begin
        do_resume();
      end else if (r == 8) begin
        m = 5'd1 << $urandom_range(0, 4);
        drive_btn(m, $urandom_range(1, 3));
      end else begin
        press(5'b10000);
      end
    end

    repeat (20) @(posedge clock);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expectations got=%0d left want=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/guess_entry_nexysa7.md
# guess_entry_NexysA7

Button-driven entry for a 4-digit Bulls & Cows guess on the Nexys A7. The block debounces the five push-buttons and lets the player edit four decimal digits with a cursor. It checks on commit that the four digits are distinct, then hands the guess to the game controller. Its outputs use the 6-bit digit code the display driver consumes, so they wire straight into that driver's d1..d4 inputs.

## Interface
- DEBOUNCE_COUNT, default 500000: consecutive stable cycles required to accept a button level change (5 ms at 100 MHz).
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_up, btn_down, btn_left, btn_right, btn_center  in  1 each  raw, asynchronous, active-high push-buttons.
- resume  in  1  controller request to leave WAIT and return to EDIT. Sampled only in WAIT.
- d1, d2, d3, d4  out  6 each  display digit codes. d1 is the rightmost, least-significant digit. Format: {enable, glyph[3:0], dp_n}. enable is always 1, glyph is the digit 0–9, and dp_n=0 lights the decimal point.
- guess  out  16  four BCD digits {d4, d3, d2, d1}.
- guess_valid  out  1  one-cycle pulse: the committed guess has 4 distinct digits.
- guess_error  out  1  one-cycle pulse: the committed guess has a repeated digit.

## Operation
- **Debounce, per button:**
  - 2-FF synchronizer feeds stable-level register db (reset 0) and a 32-bit counter (reset 0).
  - When the synchronized value s2 equals db, the counter clears.
  - When s2 differs from db, the counter increments. On the cycle it equals DEBOUNCE_COUNT-1, db takes s2 and the counter clears.
  - A press pulse (registered, one cycle) fires only on the 0→1 db transition.
  - Any glitch shorter than DEBOUNCE_COUNT cycles is ignored.
- **Same-cycle presses:** one action per cycle, priority center > up > down > left > right. Lower-priority pulses in that cycle are dropped.
- **Cursor:** cursor[1:0] = 0 selects d1, 3 selects d4.
  - Only the selected digit shows dp_n=0, and only in EDIT. All other digits show dp_n=1.
  - In CHECK and WAIT, every dp_n is 1.
- **FSM states:** EDIT, CHECK, WAIT.
  - EDIT, up: the digit at the cursor increments; 9 wraps to 0.
  - EDIT, down: the digit decrements; 0 wraps to 9.
  - EDIT, left: cursor+1, with 3 wrapping to 0.
  - EDIT, right: cursor-1, with 0 wrapping to 3.
  - EDIT, center: go to CHECK.
  - CHECK, one cycle. If the four digits are pairwise distinct (6 comparisons), pulse guess_valid and go to WAIT. Otherwise pulse guess_error and go to EDIT.
  - WAIT: all button pulses are ignored and digits are frozen. resume=1 goes to EDIT with digits and cursor retained.
- **Digit range:** digit registers hold only 0–9; glyph codes A–F are never produced.
- **Reset values:**
  - Digits {d4..d1} = 0,1,2,3, so guess = 16'h0123.
  - cursor = 0, state EDIT.
  - d1 = 6'b100110; d2 = 6'b100101; d3 = 6'b100011; d4 = 6'b100001.
  - guess_valid = guess_error = 0. All synchronizer, db and counter state = 0.

## Timing
- All outputs are registered.
- **Button latency:**
  - A raw button held high from before edge 1 is captured by s1 at edge 1 and by s2 at edge 2.
  - The press pulse is asserted after edge 2+DEBOUNCE_COUNT.
  - The digit or cursor change appears on the outputs after edge 3+DEBOUNCE_COUNT.
- **Release:** also needs DEBOUNCE_COUNT stable cycles but produces no pulse. A second press needs a full release first.
- **Commit:**
  - A center pulse seen in EDIT at edge N gives state CHECK after edge N.
  - guess_valid or guess_error is high for exactly the cycle after edge N+1, with the state already WAIT or EDIT.
  - guess is stable from CHECK through WAIT.
- **resume:** high at edge M in WAIT gives EDIT after M. resume outside WAIT has no effect.
- **Reset mid-operation:** all state returns to reset values immediately. A button held through reset deassertion is re-debounced and yields one press.

## Test plan
- Reset release, no buttons → d1..d4 = 6'b100110, 6'b100101, 6'b100011, 6'b100001; guess = 16'h0123; no pulses.
- DEBOUNCE_COUNT=4. Hold btn_up 20 cycles → exactly one increment, guess = 16'h0124, with the change 7 edges after the raw rise. A 3-cycle btn_up glitch → no change.
- Press down four times at cursor 0 from digit 3 → 2, 1, 0, 9. Press left four times → cursor returns to 0, with the dp moving d2, d3, d4, d1.
- From reset, center → guess_valid for one cycle two edges after the pulse; state WAIT. Button presses are then ignored. resume → EDIT with the dp on d1 again.
- Set d1=2, giving guess 16'h0122, then center → guess_error one cycle, guess_valid 0, back to EDIT with the cursor retained.
- btn_center and btn_up pulses on the same cycle → CHECK entered, digit unchanged. Assert reset during WAIT → all outputs at reset values.
